// File: rtl/riscv_define.sv
// Shared definitions for the register file slice.
//   REG_ZERO        index of the hardwired-zero register
//   `RegBus         register-width data declaration (uses XLEN in the declaring scope)
//   `RegAddrBus     register-index declaration (uses AW in the declaring scope)
//   slice_lo()      low bit of port k in a flat vector of w-bit fields
`ifndef RISCV_DEFINE_SV
`define RISCV_DEFINE_SV

`define RegBus     logic [XLEN-1:0]
`define RegAddrBus logic [AW-1:0]

package riscv_define;

  localparam int REG_ZERO = 0;

  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

`endif

// File: rtl/riscv_regfile_mp_if.sv
// Bus bundle between issue/write-back logic (master) and the register file (slave).
//   rs_idx_i / rs_val_o / rs_busy_o  : NRD combinational read + busy query ports
//   wb_we_i / wb_idx_i / wb_val_i / wb_clr_i : NWR write-back ports
//   iss_valid_i / iss_idx_i          : destination of the instruction issuing this cycle
interface riscv_regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 4,
  parameter int NWR  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]   rs_idx_i;
  logic [NRD*XLEN-1:0] rs_val_o;
  logic [NRD-1:0]      rs_busy_o;
  logic [NWR-1:0]      wb_we_i;
  logic [NWR*AW-1:0]   wb_idx_i;
  logic [NWR*XLEN-1:0] wb_val_i;
  logic [NWR-1:0]      wb_clr_i;
  logic                iss_valid_i;
  logic [AW-1:0]       iss_idx_i;

  modport master (
    output rs_idx_i, wb_we_i, wb_idx_i, wb_val_i, wb_clr_i, iss_valid_i, iss_idx_i,
    input  rs_val_o, rs_busy_o
  );

  modport slave (
    input  rs_idx_i, wb_we_i, wb_idx_i, wb_val_i, wb_clr_i, iss_valid_i, iss_idx_i,
    output rs_val_o, rs_busy_o
  );
endinterface

// File: rtl/riscv_regfile_mp_busy.sv
// riscv_busy_table: one busy bit per architectural register.
//   clk, rst        clock, synchronous active-high reset (clears every bit)
//   i_set_valid/idx set busy[idx] at the edge (idx 0 ignored)
//   i_clr_en/idx    NWR clear requests, flat index vector
//   i_q_idx         NRD query indices, flat
//   o_q_busy        stored busy bit for each query (no same-cycle forwarding)
module riscv_busy_table
  import riscv_define::*;
#(
  parameter int NREG = 32,
  parameter int NWR  = 2,
  parameter int NRD  = 4,
  parameter int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_set_valid,
  input  logic [AW-1:0]     i_set_idx,
  input  logic [NWR-1:0]    i_clr_en,
  input  logic [NWR*AW-1:0] i_clr_idx,
  input  logic [NRD*AW-1:0] i_q_idx,
  output logic [NRD-1:0]    o_q_busy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;

  // Set is applied after all clears: a new producer is younger than a retiring one.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int p = 0; p < NWR; p++) begin
      if (i_clr_en[p]) w_busy_nxt[i_clr_idx[slice_lo(p, AW) +: AW]] = 1'b0;
    end
    if (i_set_valid && (i_set_idx != AW'(REG_ZERO))) w_busy_nxt[i_set_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_q
    assign o_q_busy[k] = r_busy[i_q_idx[slice_lo(k, AW) +: AW]];
  end

endmodule

// File: rtl/riscv_regfile_mp.sv
// riscv_regfile_mp: multi-port integer register file with busy scoreboard.
//   clk   clock, all state updates on posedge
//   rst   synchronous active-high reset (data and busy bits cleared)
//   bus   slave side of riscv_regfile_mp_if: NRD read/busy ports, NWR write-back
//         ports, one issue-set port
// Register 0 reads as zero, never busy, and ignores writes and issue-sets.
module riscv_regfile_mp
  import riscv_define::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 4,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input logic               clk,
  input logic               rst,
  riscv_regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREG);

  `RegBus r_regs [NREG];

  logic [NRD-1:0] w_busy_q;

  // Later ports overwrite earlier ones, so the highest-numbered port wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (bus.wb_we_i[p] && (bus.wb_idx_i[slice_lo(p, AW) +: AW] != AW'(REG_ZERO)))
          r_regs[bus.wb_idx_i[slice_lo(p, AW) +: AW]] <= bus.wb_val_i[slice_lo(p, XLEN) +: XLEN];
      end
    end
  end

  riscv_busy_table #(
    .NREG (NREG),
    .NWR  (NWR),
    .NRD  (NRD),
    .AW   (AW)
  ) u_busy (
    .clk         (clk),
    .rst         (rst),
    .i_set_valid (bus.iss_valid_i),
    .i_set_idx   (bus.iss_idx_i),
    .i_clr_en    (bus.wb_we_i & bus.wb_clr_i),
    .i_clr_idx   (bus.wb_idx_i),
    .i_q_idx     (bus.rs_idx_i),
    .o_q_busy    (w_busy_q)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    `RegAddrBus w_idx;
    `RegBus     w_val;
    logic       w_clr_hit;

    assign w_idx = bus.rs_idx_i[slice_lo(k, AW) +: AW];

    // While rst is high the stored view reads as zero, but live write-back
    // data is still forwarded.
    always_comb begin
      w_val     = rst ? '0 : r_regs[w_idx];
      w_clr_hit = 1'b0;
      if (BYPASS != 0) begin
        for (int p = 0; p < NWR; p++) begin
          if (bus.wb_we_i[p] && (bus.wb_idx_i[slice_lo(p, AW) +: AW] == w_idx)) begin
            w_val = bus.wb_val_i[slice_lo(p, XLEN) +: XLEN];
            if (bus.wb_clr_i[p]) w_clr_hit = 1'b1;
          end
        end
      end
      if (w_idx == AW'(REG_ZERO)) w_val = '0;
    end

    assign bus.rs_val_o[slice_lo(k, XLEN) +: XLEN] = w_val;
    assign bus.rs_busy_o[k] = ~rst & w_busy_q[k] & ~w_clr_hit;
  end

endmodule
